// File: rtl/prince_sbox_cms_layer_if.sv
// Stream interface for the masked PRINCE S-box layer: input shares plus randomness in,
// output shares out, each direction with its own valid/ready pair.
interface prince_sbox_cms_layer_if #(
  parameter int NUM_SBOX = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NUM_SBOX-1:0]  in_sh0;
  logic [4*NUM_SBOX-1:0]  in_sh1;
  logic [60*NUM_SBOX-1:0] rnd;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NUM_SBOX-1:0]  out_sh0;
  logic [4*NUM_SBOX-1:0]  out_sh1;

  // Valid/ready: a word moves on a rising clk edge where valid && ready; until then the
  // sender holds valid high and its data stable, and ready may depend on the far side.
  modport master (
    output in_valid, in_sh0, in_sh1, rnd, out_ready,
    input  in_ready, out_valid, out_sh0, out_sh1
  );

  modport slave (
    input  in_valid, in_sh0, in_sh1, rnd, out_ready,
    output in_ready, out_valid, out_sh0, out_sh1
  );
endinterface

// File: rtl/prince_sbox_cms_layer.sv
// First-order masked PRINCE S-box layer: non-complete share expansion into 16 partials,
// refresh, register, compress to two shares, register. Two-stage valid/ready pipeline.
module prince_sbox_cms_layer #(
  parameter int NUM_SBOX = 16,
  parameter bit INVERSE  = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  prince_sbox_cms_layer_if.slave bus
);
  localparam int W  = 4 * NUM_SBOX;
  localparam int NP = 64 * NUM_SBOX;

  // ANF coefficients of each output bit j at [16*j + m]; monomial mask m uses bit3=x .. bit0=w.
  function automatic logic [63:0] anf_table(input bit inv);
    logic [63:0] lut;
    logic [63:0] a;
    lut = inv ? 64'h1CE5046A98DF237B : 64'h4D5E087619CA23FB;
    a   = '0;
    for (int j = 0; j < 4; j++)
      for (int x = 0; x < 16; x++)
        a[16*j+x] = lut[4*x+j];
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        for (int x = 0; x < 16; x++)
          if (((x >> i) & 1) == 1) a[16*j+x] = a[16*j+x] ^ a[16*j+(x ^ (1 << i))];
    return a;
  endfunction

  localparam logic [63:0] ANF = anf_table(INVERSE);

  logic          v1_q, v2_q;
  logic [NP-1:0] part_d, part_q;
  logic [W-1:0]  sh0_d, sh0_q, sh1_d, sh1_q;
  logic          s2_load, in_fire;

  always_comb begin
    logic [3:0]  a, b, pv, mv;
    logic [15:0] r_ext;
    logic        acc, term;
    part_d = '0;
    a = '0; b = '0; pv = '0; mv = '0; r_ext = '0; acc = 1'b0; term = 1'b0;
    for (int s = 0; s < NUM_SBOX; s++) begin
      a = bus.in_sh0[4*s +: 4];
      b = bus.in_sh1[4*s +: 4];
      for (int j = 0; j < 4; j++) begin
        // Partial 15 absorbs the XOR of the other 15 mask bits so the share sum is unchanged.
        r_ext = {^bus.rnd[60*s+15*j +: 15], bus.rnd[60*s+15*j +: 15]};
        for (int p = 0; p < 16; p++) begin
          pv  = 4'(p);
          acc = 1'b0;
          for (int m = 0; m < 16; m++) begin
            mv = 4'(m);
            // Partial p only owns terms whose unused variables select share 0.
            if (ANF[16*j+m] && ((pv & ~mv) == 4'h0)) begin
              term = 1'b1;
              for (int k = 0; k < 4; k++)
                if (mv[k]) term = term & (pv[k] ? b[k] : a[k]);
              acc = acc ^ term;
            end
          end
          part_d[(s*4+j)*16+p] = acc ^ r_ext[pv];
        end
      end
    end
  end

  always_comb begin
    sh0_d = '0;
    sh1_d = '0;
    for (int s = 0; s < NUM_SBOX; s++)
      for (int j = 0; j < 4; j++) begin
        sh0_d[4*s+j] = ^part_q[(s*4+j)*16 +: 8];
        sh1_d[4*s+j] = ^part_q[(s*4+j)*16+8 +: 8];
      end
  end

  assign s2_load      = !v2_q || bus.out_ready;
  assign bus.in_ready = !v1_q || s2_load;
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      part_q <= '0;
      sh0_q  <= '0;
      sh1_q  <= '0;
    end else begin
      if (in_fire) begin
        v1_q   <= 1'b1;
        part_q <= part_d;
      end else if (s2_load) begin
        v1_q <= 1'b0;
      end
      if (s2_load) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sh0_q <= sh0_d;
          sh1_q <= sh1_d;
        end
      end
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.out_sh0   = sh0_q;
  assign bus.out_sh1   = sh1_q;
endmodule

// File: doc/prince_sbox_cms_layer.md
Name: prince_sbox_cms_layer

Overview:
Parametrised, pipelined, first-order masked PRINCE S-box layer using non-complete share functions (CMS style). It generalises the single-bit, single-share combinational share functions to a full layer of NUM_SBOX S-boxes.
- Each S-box takes a 2-share nibble and expands it into 16 non-complete partial shares.
- The partials are refreshed with fresh randomness, registered, compressed back to 2 shares and registered again.
- The layer sits between the PRINCE linear layers and runs forward (S) or inverse (S^-1) mode.

Parameters:
NUM_SBOX, 16, number of parallel 4-bit S-boxes (1..16)
INVERSE, 0, 0 = PRINCE S, 1 = PRINCE S^-1 (elaboration-time)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  input shares valid
in_ready  output  1  layer accepts input this cycle
in_sh0  input  4*NUM_SBOX  input share 0, S-box i in bits [4i+3:4i]
in_sh1  input  4*NUM_SBOX  input share 1
rnd  input  60*NUM_SBOX  fresh randomness: 15 bits per output bit per S-box
out_valid  output  1  output shares valid
out_ready  input  1  downstream accepts output
out_sh0  output  4*NUM_SBOX  output share 0
out_sh1  output  4*NUM_SBOX  output share 1

Behaviour:
- Nibble convention: bit3=x, bit2=y, bit1=z, bit0=w.
- Forward S = B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4 (index 0..F).
- Inverse S^-1 = B,7,3,2,F,D,8,9,A,6,4,0,5,E,C,1.
- Partial construction, per S-box and per output bit j:
  - Use the ANF of S_j.
  - Expand every monomial over the shares of its variables.
  - Assign each cross term to partial p = (sx,sy,sz,sw), where each s is in {0,1}.
  - The share index of each variable used in the term sets its position in p; unused variables take 0.
  - The ANF constant term goes to partial 0000.
  - Non-completeness: partial p reads only share s_v of each variable v.
- Refresh (per output bit):
  - Partials 0..14 are XORed with rnd bits r0..r14.
  - Partial 15 is XORed with r0^r1^...^r14.
  - The sum is unchanged by the refresh.
- Stage 1 register: holds 16 refreshed partials per output bit per S-box, plus v1.
- Stage 2 register:
  - out_sh0 = XOR of partials 0..7.
  - out_sh1 = XOR of partials 8..15.
  - Also holds v2, which drives out_valid.
- Latency: 2 cycles from accepted input to out_valid.
- Throughput: 1 per cycle when out_ready is held high.
- Handshake and stalls:
  - A transfer occurs when valid && ready.
  - Stage 2 loads when (!v2 || out_ready).
  - in_ready = !v1 || stage-2-loads.
  - v1 clears when stage 2 takes its contents and no new input arrives.
  - While out_valid=1 and out_ready=0, out_sh0, out_sh1 and out_valid hold stable.
- Randomness:
  - rnd is sampled only on an accepted input transfer.
  - No combinational path from rnd to any output.
- Reset:
  - v1, v2, out_valid = 0; all data registers = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards in-flight data with no output pulse.
- Combinational paths:
  - Only out_ready to in_ready; no other input-to-output combinational path.
- in_valid with no transfer (in_ready=0): inputs are ignored and the source must hold them.

Test Plan:
- Forward, NUM_SBOX=16: input XOR nibbles 0..F (random share split, random rnd) -> after 2 cycles, out_sh0^out_sh1 = B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4.
- INVERSE=1: feed the forward outputs -> unmasked result returns 0..F. Input 0 (shares 5/5) -> unmasked B.
- rnd=0 with sh1=0 vs rnd random with the same unmasked inputs -> identical unmasked outputs. Individual shares differ for nonzero rnd.
- Backpressure: stream 4 words with out_ready low for 3 cycles mid-stream -> outputs held stable, in_ready drops when both stages are full, no loss or duplication, order preserved.
- Reset mid-op: assert rst with v1=v2=1 -> out_valid=0 immediately, no stale output after release, next input produces a correct output after 2 cycles.
- NUM_SBOX=1: exhaustive 16 inputs x 4 share splits -> all unmasked results correct, sustained 1 result per cycle.
